// File: rtl/conv_weight_buffer.sv
// Writable multi-kernel weight/bias store streaming one set per pass to the PE array.
// Optional stored even parity per word when WEIGHT_PARITY_EN is defined.
module conv_weight_buffer #(
   parameter int WIDTH       = 32,
   parameter int KERNEL_SIZE = 3,
   parameter int KERNEL_NUM  = 4,
   parameter int ADDR_WIDTH  = 6,
   parameter int KSEL_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2:0]            current_state,
   input  logic [KSEL_WIDTH-1:0] kernel_sel,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   output logic [WIDTH-1:0]      o_weight,
   output logic                  o_weight_valid,
   output logic                  o_bias_flag,
   output logic                  o_set_done,
   output logic                  o_parity_err
);

   localparam int SET_WORDS = KERNEL_SIZE * KERNEL_SIZE + 1;
   localparam int DEPTH     = KERNEL_NUM * SET_WORDS;

   localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [KSEL_WIDTH:0]   KNUM_W   = (KSEL_WIDTH + 1)'(KERNEL_NUM);
   localparam logic [KSEL_WIDTH-1:0] KMAX     = KSEL_WIDTH'(KERNEL_NUM - 1);
   localparam logic [ADDR_WIDTH-1:0] SET_W    = ADDR_WIDTH'(SET_WORDS);
   localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(SET_WORDS - 1);

   typedef enum logic [2:0] {
      S_INIT    = 3'd0,
      S_PRELOAD = 3'd1,
      S_ROW_0   = 3'd2,
      S_ROW_1   = 3'd3,
      S_ROW_2   = 3'd4,
      S_BIAS    = 3'd5,
      S_LOAD    = 3'd6,
      S_IDLE    = 3'd7
   } state_e;

   state_e st;
   assign st = state_e'(current_state);

   logic [WIDTH-1:0] mem_q [0:DEPTH-1];

   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [WIDTH-1:0]      weight_q, weight_d;
   logic                  valid_q, valid_d;
   logic                  bias_q, bias_d;
   logic                  done_q, done_d;

   logic [KSEL_WIDTH-1:0] ksel_c;
   logic [ADDR_WIDTH-1:0] ksel_base;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [WIDTH-1:0]      rd_word;
   logic                  wr_ok;
   logic                  fetch;
   logic                  load_entry;
   logic                  rd_bad;

   assign ksel_c    = ({1'b0, kernel_sel} >= KNUM_W) ? KMAX : kernel_sel;
   assign ksel_base = ADDR_WIDTH'(ksel_c) * SET_W;
   assign rd_addr   = base_q + ptr_q;
   assign rd_word   = mem_q[rd_addr];
   assign wr_ok     = wr_en && ({1'b0, wr_addr} < DEPTH_W);

   // Storage is deliberately outside the reset domain so weights survive rst_n.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

`ifdef WEIGHT_PARITY_EN
   logic par_q [0:DEPTH-1];
   logic perr_q, perr_d;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         par_q[wr_addr] <= ^wr_data;
      end
   end

   assign rd_bad = par_q[rd_addr] != (^rd_word);

   always_comb begin
      perr_d = perr_q;
      if (load_entry) begin
         perr_d = 1'b0;
      end else if (fetch && rd_bad) begin
         perr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end

   assign o_parity_err = perr_q;
`else
   assign rd_bad       = 1'b0;
   assign o_parity_err = 1'b0;
`endif

   always_comb begin
      ptr_d      = ptr_q;
      base_d     = base_q;
      weight_d   = '0;
      valid_d    = 1'b0;
      bias_d     = 1'b0;
      done_d     = 1'b0;
      fetch      = 1'b0;
      load_entry = 1'b0;
      case (st)
         S_PRELOAD: begin
            ptr_d  = '0;
            base_d = ksel_base;
         end
         S_LOAD: begin
            ptr_d      = '0;
            base_d     = ksel_base;
            load_entry = 1'b1;
         end
         S_ROW_0, S_ROW_1, S_ROW_2, S_BIAS: begin
            fetch    = 1'b1;
            weight_d = rd_word;
            valid_d  = 1'b1;
            if (ptr_q == PTR_LAST) begin
               ptr_d  = '0;
               bias_d = 1'b1;
               done_d = 1'b1;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= '0;
         base_q   <= '0;
         weight_q <= '0;
         valid_q  <= 1'b0;
         bias_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         ptr_q    <= ptr_d;
         base_q   <= base_d;
         weight_q <= weight_d;
         valid_q  <= valid_d;
         bias_q   <= bias_d;
         done_q   <= done_d;
      end
   end

   assign o_weight       = weight_q;
   assign o_weight_valid = valid_q;
   assign o_bias_flag    = bias_q;
   assign o_set_done     = done_q;

endmodule

// File: tb/tb_conv_weight_buffer.sv
// Directed bench for conv_weight_buffer, plus a KERNEL_NUM=3 instance for the clamp.
// Parity checks are compiled in when WEIGHT_PARITY_EN is defined.
module tb_conv_weight_buffer;

   localparam logic [2:0] INIT = 3'd0, PRELOAD = 3'd1, ROW_0 = 3'd2;
   localparam logic [2:0] ROW_1 = 3'd3, ROW_2 = 3'd4, BIAS = 3'd5;
   localparam logic [2:0] LOAD = 3'd6, IDLE = 3'd7;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  cs;
   logic [1:0]  ksel;
   logic        we;
   logic [5:0]  waddr;
   logic [31:0] wdata;

   logic [31:0] w, w3;
   logic        v, v3, bf, bf3, sd, sd3, pe, pe3;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   conv_weight_buffer dut (
      .clk(clk), .rst_n(rst_n), .current_state(cs), .kernel_sel(ksel),
      .wr_en(we), .wr_addr(waddr), .wr_data(wdata),
      .o_weight(w), .o_weight_valid(v), .o_bias_flag(bf),
      .o_set_done(sd), .o_parity_err(pe)
   );

   conv_weight_buffer #(.KERNEL_NUM(3)) u_k3 (
      .clk(clk), .rst_n(rst_n), .current_state(cs), .kernel_sel(ksel),
      .wr_en(we), .wr_addr(waddr), .wr_data(wdata),
      .o_weight(w3), .o_weight_valid(v3), .o_bias_flag(bf3),
      .o_set_done(sd3), .o_parity_err(pe3)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] row_st(input int i);
      if (i < 3) return ROW_0;
      if (i < 6) return ROW_1;
      if (i < 9) return ROW_2;
      return BIAS;
   endfunction

   initial begin
      rst_n = 1'b0; cs = INIT; ksel = 2'd0;
      we = 1'b0; waddr = '0; wdata = '0;
      tick(); tick();
      chk("rst_weight", w, 32'h0);
      chk("rst_valid", {31'b0, v}, 32'h0);
      chk("rst_bias", {31'b0, bf}, 32'h0);
      chk("rst_done", {31'b0, sd}, 32'h0);
      chk("rst_perr", {31'b0, pe}, 32'h0);
      rst_n = 1'b1;

      // Set 1 at 10..19 and set 2 at 20..29 (both instances)
      for (int i = 0; i < 20; i++) begin
         we = 1'b1; waddr = 6'(10 + i);
         wdata = (i < 10) ? 32'h100 + 32'(i) : 32'h200 + 32'(i - 10);
         tick();
      end
      // Out-of-range write must not disturb anything visible
      waddr = 6'd50; wdata = 32'hBAD0BAD0; tick();
      we = 1'b0;

      cs = PRELOAD; ksel = 2'd1; tick();
      chk("preload_valid", {31'b0, v}, 32'h0);
      for (int i = 0; i < 10; i++) begin
         cs = row_st(i); tick();
         chk($sformatf("set1_w%0d", i), w, 32'h100 + 32'(i));
         chk($sformatf("set1_v%0d", i), {31'b0, v}, 32'h1);
         chk($sformatf("set1_bf%0d", i), {31'b0, bf}, (i == 9) ? 32'h1 : 32'h0);
         chk($sformatf("set1_sd%0d", i), {31'b0, sd}, (i == 9) ? 32'h1 : 32'h0);
      end
      cs = ROW_0; tick();
      chk("wrap_w0", w, 32'h100);
      chk("wrap_sd0", {31'b0, sd}, 32'h0);
      tick();
      chk("wrap_w1", w, 32'h101);
      chk("wrap_bf1", {31'b0, bf}, 32'h0);

      // Hold in IDLE after ptr 0..3
      cs = PRELOAD; tick();
      for (int i = 0; i < 4; i++) begin
         cs = ROW_0; tick();
      end
      chk("pre_idle_w", w, 32'h103);
      cs = IDLE;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("idle_w", w, 32'h0);
         chk("idle_v", {31'b0, v}, 32'h0);
      end
      cs = ROW_1; tick();
      chk("resume_w", w, 32'h104);

      // Same-cycle write/read of address 12
      cs = PRELOAD; tick();
      cs = ROW_0; tick(); tick();
      we = 1'b1; waddr = 6'd12; wdata = 32'hDEAD; tick();
      we = 1'b0;
      chk("rw_old", w, 32'h102);
      cs = PRELOAD; tick();
      cs = ROW_0; tick(); tick(); tick();
      chk("rw_new", w, 32'hDEAD);

      // Async reset mid-stream at ptr=5
      cs = PRELOAD; tick();
      for (int i = 0; i < 6; i++) begin
         cs = row_st(i); tick();
      end
      chk("mid_w", w, 32'h105);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_w", w, 32'h0);
      chk("arst_v", {31'b0, v}, 32'h0);
      chk("arst_bf", {31'b0, bf}, 32'h0);
      chk("arst_sd", {31'b0, sd}, 32'h0);
      cs = INIT; tick();
      rst_n = 1'b1; tick();
      cs = PRELOAD; ksel = 2'd1; tick();
      cs = ROW_0; tick();
      chk("retain_w", w, 32'h100);
      ksel = 2'd0; tick();
      chk("ksel_ignored", w, 32'h101);

      // Clamp: kernel_sel=3 on KERNEL_NUM=3 streams set 2
      cs = PRELOAD; ksel = 2'd3; tick();
      cs = ROW_0; tick();
      chk("clamp_w0", w3, 32'h200);
      tick();
      chk("clamp_w1", w3, 32'h201);

`ifdef WEIGHT_PARITY_EN
      dut.mem_q[12] = dut.mem_q[12] ^ 32'h1;
      cs = PRELOAD; ksel = 2'd1; tick();
      cs = ROW_0; tick(); tick();
      chk("par_clean", {31'b0, pe}, 32'h0);
      tick();
      chk("par_bad_w", w, 32'hDEAC);
      chk("par_err", {31'b0, pe}, 32'h1);
      tick(); tick();
      chk("par_sticky", {31'b0, pe}, 32'h1);
      cs = LOAD; tick();
      chk("par_clr", {31'b0, pe}, 32'h0);
`else
      chk("par_tied", {31'b0, pe}, 32'h0);
`endif

      cs = IDLE; tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
